axi4_burst_ram_ctrl: RTL and testbench

AXI4 (full, no ID) slave-side burst sequencer for the on-chip logic RAM wrapper.
- Accepts AW/W/B and AR/R channel traffic and arbitrates between the read and write requesters for the single-ported RAM.
- Generates burst addresses and drives the RAM wrapper's control inputs: axi_awaddr, axi_araddr, axi_awv_awr_flag, axi_arv_arr_flag, axi_wready and axi_rvalid.
- Sits between the AXI interconnect port and the RAM wrapper. RDATA comes from the wrapper; it is not part of this block.

---
 rtl/axi4_burst_ram_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_axi4_burst_ram_ctrl.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_burst_ram_ctrl.sv
// AXI4 burst sequencer for a single-ported RAM wrapper (FIXED/INCR/WRAP).
// Define AXI4_WRAP_BURST_EN for true WRAP bursts; otherwise WRAP acts as INCR.
module axi4_burst_ram_ctrl #(
  parameter int C_S_AXI_ADDR_WIDTH = 6,
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int ADDR_LSB = (C_S_AXI_DATA_WIDTH / 32) + 1
) (
  input  logic                          S_AXI_ACLK,
  input  logic                          S_AXI_ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_AWADDR,
  input  logic [7:0]                    S_AXI_AWLEN,
  input  logic [1:0]                    S_AXI_AWBURST,
  input  logic                          S_AXI_AWVALID,
  output logic                          S_AXI_AWREADY,
  input  logic                          S_AXI_WVALID,
  input  logic                          S_AXI_WLAST,
  output logic [1:0]                    S_AXI_BRESP,
  output logic                          S_AXI_BVALID,
  input  logic                          S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_ARADDR,
  input  logic [7:0]                    S_AXI_ARLEN,
  input  logic [1:0]                    S_AXI_ARBURST,
  input  logic                          S_AXI_ARVALID,
  output logic                          S_AXI_ARREADY,
  input  logic                          S_AXI_RREADY,
  output logic                          S_AXI_RLAST,
  output logic [1:0]                    S_AXI_RRESP,
  output logic                          axi_wready,
  output logic                          axi_rvalid,
  output logic                          axi_awv_awr_flag,
  output logic                          axi_arv_arr_flag,
  output logic [C_S_AXI_ADDR_WIDTH-1:0] axi_awaddr,
  output logic [C_S_AXI_ADDR_WIDTH-1:0] axi_araddr
);

  localparam int AW = C_S_AXI_ADDR_WIDTH;
  localparam logic [AW-1:0] INC = AW'(1 << ADDR_LSB);

`ifdef AXI4_WRAP_BURST_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE,
    WDATA,
    WRESP,
    RWAIT,
    RDATA
  } state_t;

  state_t        state_q, state_d;
  logic          last_rd_q, last_rd_d;
  logic [AW-1:0] awaddr_q, awaddr_d;
  logic [AW-1:0] araddr_q, araddr_d;
  logic [7:0]    len_q, len_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [1:0]    burst_q, burst_d;
  logic          err_q, err_d;
  logic          awready, arready;
  logic          grant_w, grant_r;
  logic          final_beat;

  function automatic logic len_ok(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) ||
           (len == 8'd7) || (len == 8'd15);
  endfunction

  function automatic logic wrap_ok(input logic [1:0] burst,
                                   input logic [7:0] len);
    return WRAP_EN && (burst == 2'b10) && len_ok(len);
  endfunction

  function automatic logic bad_wrap(input logic [1:0] burst,
                                    input logic [7:0] len);
    return WRAP_EN && (burst == 2'b10) && !len_ok(len);
  endfunction

  function automatic logic [AW-1:0] next_addr(
    input logic [AW-1:0] addr,
    input logic [1:0]    burst,
    input logic [7:0]    len
  );
    logic [AW-1:0] inc;
    logic [AW-1:0] mask;
    logic [15:0]   bnd;
    inc  = addr + INC;
    bnd  = (16'(len) + 16'd1) << ADDR_LSB;
    mask = AW'(bnd - 16'd1);
    if (burst == 2'b00) return addr;
    if (wrap_ok(burst, len)) return (addr & ~mask) | (inc & mask);
    return inc;
  endfunction

  assign final_beat = (cnt_q == len_q);
  // Contention goes to whichever side did not win last time.
  assign grant_w = S_AXI_AWVALID && (!S_AXI_ARVALID || last_rd_q);
  assign grant_r = S_AXI_ARVALID && !grant_w;

  always_comb begin
    state_d   = state_q;
    last_rd_d = last_rd_q;
    awaddr_d  = awaddr_q;
    araddr_d  = araddr_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    burst_d   = burst_q;
    err_d     = err_q;
    awready   = 1'b0;
    arready   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (grant_w) begin
          awready   = 1'b1;
          awaddr_d  = S_AXI_AWADDR;
          len_d     = S_AXI_AWLEN;
          burst_d   = S_AXI_AWBURST;
          cnt_d     = 8'd0;
          err_d     = bad_wrap(S_AXI_AWBURST, S_AXI_AWLEN);
          last_rd_d = 1'b0;
          state_d   = WDATA;
        end else if (grant_r) begin
          arready   = 1'b1;
          araddr_d  = S_AXI_ARADDR;
          len_d     = S_AXI_ARLEN;
          burst_d   = S_AXI_ARBURST;
          cnt_d     = 8'd0;
          err_d     = bad_wrap(S_AXI_ARBURST, S_AXI_ARLEN);
          last_rd_d = 1'b1;
          state_d   = RWAIT;
        end
      end
      WDATA: begin
        if (S_AXI_WVALID) begin
          // Burst length is taken from AWLEN; WLAST only flags errors.
          err_d    = err_q | (S_AXI_WLAST != final_beat);
          awaddr_d = next_addr(awaddr_q, burst_q, len_q);
          cnt_d    = cnt_q + 8'd1;
          if (final_beat) state_d = WRESP;
        end
      end
      WRESP: begin
        if (S_AXI_BREADY) begin
          err_d   = 1'b0;
          state_d = IDLE;
        end
      end
      RWAIT: state_d = RDATA;
      RDATA: begin
        if (S_AXI_RREADY) begin
          if (final_beat) begin
            err_d   = 1'b0;
            state_d = IDLE;
          end else begin
            araddr_d = next_addr(araddr_q, burst_q, len_q);
            cnt_d    = cnt_q + 8'd1;
            state_d  = RWAIT;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      state_q   <= IDLE;
      last_rd_q <= 1'b1;
      awaddr_q  <= '0;
      araddr_q  <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      burst_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_rd_q <= last_rd_d;
      awaddr_q  <= awaddr_d;
      araddr_q  <= araddr_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      burst_q   <= burst_d;
      err_q     <= err_d;
    end
  end

  // The ready strobes are combinational, so mask them while in reset.
  assign S_AXI_AWREADY    = awready & ~S_AXI_ARESET;
  assign S_AXI_ARREADY    = arready & ~S_AXI_ARESET;
  assign axi_wready       = (state_q == WDATA);
  assign axi_awv_awr_flag = (state_q == WDATA);
  assign S_AXI_BVALID     = (state_q == WRESP);
  assign S_AXI_BRESP      = (state_q == WRESP && err_q) ? 2'b10 : 2'b00;
  assign axi_arv_arr_flag = (state_q == RWAIT);
  assign axi_rvalid       = (state_q == RDATA);
  assign S_AXI_RLAST      = (state_q == RDATA) && final_beat;
  assign S_AXI_RRESP      = (state_q == RDATA && err_q) ? 2'b10 : 2'b00;
  assign axi_awaddr       = awaddr_q;
  assign axi_araddr       = araddr_q;

endmodule

// File: tb/tb_axi4_burst_ram_ctrl.sv
// Scoreboard bench for axi4_burst_ram_ctrl: directed cases plus random bursts
// checked against an arithmetic address/response model and a shadow RAM.
module tb_axi4_burst_ram_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] awaddr_i, araddr_i;
  logic [7:0] awlen_i, arlen_i;
  logic [1:0] awburst_i, arburst_i;
  logic       awvalid, arvalid, wvalid, wlast, bready, rready;
  logic       awready, arready, bvalid, rlast;
  logic [1:0] bresp, rresp;
  logic       axi_wready, axi_rvalid, awflag, arflag;
  logic [5:0] axi_awaddr, axi_araddr;

  always #5 clk = ~clk;

  axi4_burst_ram_ctrl dut (
    .S_AXI_ACLK       (clk),
    .S_AXI_ARESET     (rst),
    .S_AXI_AWADDR     (awaddr_i),
    .S_AXI_AWLEN      (awlen_i),
    .S_AXI_AWBURST    (awburst_i),
    .S_AXI_AWVALID    (awvalid),
    .S_AXI_AWREADY    (awready),
    .S_AXI_WVALID     (wvalid),
    .S_AXI_WLAST      (wlast),
    .S_AXI_BRESP      (bresp),
    .S_AXI_BVALID     (bvalid),
    .S_AXI_BREADY     (bready),
    .S_AXI_ARADDR     (araddr_i),
    .S_AXI_ARLEN      (arlen_i),
    .S_AXI_ARBURST    (arburst_i),
    .S_AXI_ARVALID    (arvalid),
    .S_AXI_ARREADY    (arready),
    .S_AXI_RREADY     (rready),
    .S_AXI_RLAST      (rlast),
    .S_AXI_RRESP      (rresp),
    .axi_wready       (axi_wready),
    .axi_rvalid       (axi_rvalid),
    .axi_awv_awr_flag (awflag),
    .axi_arv_arr_flag (arflag),
    .axi_awaddr       (axi_awaddr),
    .axi_araddr       (axi_araddr)
  );

  typedef struct {
    int          addr;
    bit          last;
    logic [1:0]  resp;
    logic [31:0] data;
  } rexp_t;

  int          exp_w[$];
  logic [1:0]  exp_b[$];
  rexp_t       exp_r[$];
  logic [31:0] ref_mem[16];
  logic [31:0] tb_ram[16];
  logic [31:0] tb_wdata;
  int          checks = 0;
  int          fails = 0;
  int          wl[4] = '{1, 3, 7, 15};

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Reference model: burst address rules stated as plain arithmetic.
  function automatic bit wrap_valid(int len, int burst);
`ifdef AXI4_WRAP_BURST_EN
    return burst == 2 && (len == 1 || len == 3 || len == 7 || len == 15);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [1:0] slv(int len, int burst);
`ifdef AXI4_WRAP_BURST_EN
    if (burst == 2 && !wrap_valid(len, burst)) return 2'b10;
`endif
    return 2'b00;
  endfunction

  function automatic int addr_at(int start, int len, int burst, int i);
    int b, base;
    if (burst == 0) return start;
    if (wrap_valid(len, burst)) begin
      b    = (len + 1) * 4;
      base = (start / b) * b;
      return base + ((start - base + 4 * i) % b);
    end
    return (start + 4 * i) % 64;
  endfunction

  function automatic void issue_w(int start, int len, int burst,
                                  int bad, logic [31:0] base);
    int a;
    for (int i = 0; i <= len; i++) begin
      a = addr_at(start, len, burst, i);
      exp_w.push_back(a);
      ref_mem[a / 4] = base + 32'(i);
    end
    exp_b.push_back((bad >= 0) ? 2'b10 : slv(len, burst));
  endfunction

  function automatic void issue_r(int start, int len, int burst);
    rexp_t e;
    for (int i = 0; i <= len; i++) begin
      e.addr = addr_at(start, len, burst, i);
      e.last = (i == len);
      e.resp = slv(len, burst);
      e.data = ref_mem[e.addr / 4];
      exp_r.push_back(e);
    end
  endfunction

  // Monitor: pops expectations whenever the DUT presents a beat.
  bit         prev_stall, prev_hs;
  logic [5:0] prev_ar;
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 0;
      prev_hs = 0;
    end else begin
      chk("flags_excl", 32'(awflag & arflag), 0);
      if (prev_stall) begin
        chk("r_hold_valid", 32'(axi_rvalid), 1);
        chk("r_hold_addr", 32'(axi_araddr), 32'(prev_ar));
      end
      if (prev_hs) chk("r_bubble", 32'(axi_rvalid), 0);
      if (axi_wready && wvalid) begin
        if (exp_w.size() == 0) chk("w_unexpected", 1, 0);
        else chk("w_addr", 32'(axi_awaddr), exp_w.pop_front());
        tb_ram[axi_awaddr[5:2]] = tb_wdata;
      end
      if (bvalid && bready) begin
        if (exp_b.size() == 0) chk("b_unexpected", 1, 0);
        else chk("bresp", 32'(bresp), 32'(exp_b.pop_front()));
      end
      if (axi_rvalid && rready) begin
        if (exp_r.size() == 0) chk("r_unexpected", 1, 0);
        else begin
          rexp_t e;
          e = exp_r.pop_front();
          chk("r_addr", 32'(axi_araddr), e.addr);
          chk("rlast", 32'(rlast), 32'(e.last));
          chk("rresp", 32'(rresp), 32'(e.resp));
          chk("r_data", tb_ram[axi_araddr[5:2]], e.data);
        end
      end
      prev_stall = axi_rvalid && !rready;
      prev_hs    = axi_rvalid && rready;
      prev_ar    = axi_araddr;
    end
  end

  task automatic aw_hs(int a, int len, int burst);
    int n = 0;
    awaddr_i = 6'(a); awlen_i = 8'(len); awburst_i = 2'(burst);
    awvalid = 1;
    @(negedge clk);
    while (!awready && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) chk("aw_timeout", 1, 0);
    @(posedge clk); #1 awvalid = 0;
  endtask

  task automatic ar_hs(int a, int len, int burst);
    int n = 0;
    araddr_i = 6'(a); arlen_i = 8'(len); arburst_i = 2'(burst);
    arvalid = 1;
    @(negedge clk);
    while (!arready && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) chk("ar_timeout", 1, 0);
    @(posedge clk); #1 arvalid = 0;
  endtask

  task automatic w_phase(int len, int bad, logic [31:0] base);
    int n;
    for (int i = 0; i <= len; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        wvalid = 0;
        @(posedge clk); #1;
      end
      wvalid = 1;
      wlast = (i == len) ^ (i == bad);
      tb_wdata = base + 32'(i);
      n = 0;
      @(negedge clk);
      while (!axi_wready && n < 100) begin @(negedge clk); n++; end
      if (n >= 100) chk("w_timeout", 1, 0);
      @(posedge clk); #1;
    end
    wvalid = 0; wlast = 0;
  endtask

  task automatic b_phase();
    int n = 0;
    @(negedge clk);
    while (!bvalid && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) chk("b_timeout", 1, 0);
    @(posedge clk);
    repeat ($urandom_range(0, 2)) @(posedge clk);
    #1 bready = 1;
    @(posedge clk); #1 bready = 0;
  endtask

  task automatic r_phase(int len, bit stall_first, bit keep);
    int n, d;
    rready = keep;
    for (int i = 0; i <= len; i++) begin
      n = 0;
      @(negedge clk);
      while (!axi_rvalid && n < 100) begin @(negedge clk); n++; end
      if (n >= 100) chk("r_timeout", 1, 0);
      if (keep) begin
        @(posedge clk); #1;
      end else begin
        d = (stall_first && i == 0) ? 5 : $urandom_range(0, 2);
        @(posedge clk);
        repeat (d) @(posedge clk);
        #1 rready = 1;
        @(posedge clk); #1 rready = 0;
      end
    end
    rready = 0;
  endtask

  task automatic do_write(int a, int len, int burst, int bad,
                          logic [31:0] base);
    issue_w(a, len, burst, bad, base);
    aw_hs(a, len, burst);
    w_phase(len, bad, base);
    b_phase();
  endtask

  task automatic do_read(int a, int len, int burst, bit keep);
    issue_r(a, len, burst);
    ar_hs(a, len, burst);
    r_phase(len, 1'b0, keep);
  endtask

  function automatic logic [31:0] outs();
    return 32'({awready, arready, bresp, bvalid, rlast, rresp,
                axi_wready, axi_rvalid, awflag, arflag,
                axi_awaddr, axi_araddr});
  endfunction

  initial begin
    int a, bt, ln, bad;
    for (int i = 0; i < 16; i++) begin
      ref_mem[i] = 0; tb_ram[i] = 0;
    end
    rst = 1; awvalid = 0; arvalid = 0; wvalid = 0; wlast = 0;
    bready = 0; rready = 0; tb_wdata = 0;
    awaddr_i = 0; araddr_i = 0; awlen_i = 0; arlen_i = 0;
    awburst_i = 0; arburst_i = 0;
    repeat (2) @(posedge clk);
    @(negedge clk) chk("reset_outputs", outs(), 0);
    @(posedge clk); #1 rst = 0;

    // Contention: first to write, then to read.
    issue_w(0, 1, 1, -1, 32'h1100);
    issue_r(16, 3, 1);
    awaddr_i = 0; awlen_i = 1; awburst_i = 1;
    araddr_i = 16; arlen_i = 3; arburst_i = 1;
    awvalid = 1; arvalid = 1;
    @(negedge clk);
    chk("arb1_awready", 32'(awready), 1);
    chk("arb1_arready", 32'(arready), 0);
    @(posedge clk); #1 awvalid = 0;
    w_phase(1, -1, 32'h1100);
    b_phase();
    issue_w(48, 0, 1, -1, 32'h2200);
    awaddr_i = 48; awlen_i = 0; awvalid = 1;
    @(negedge clk);
    chk("arb2_arready", 32'(arready), 1);
    chk("arb2_awready", 32'(awready), 0);
    @(posedge clk); #1 arvalid = 0;
    r_phase(3, 1'b0, 1'b0);
    aw_hs(48, 0, 1);
    w_phase(0, -1, 32'h2200);
    b_phase();

    do_write(16, 3, 1, -1, 32'hA0);
    do_read(16, 3, 1, 1'b1);

    issue_r(0, 1, 1);
    ar_hs(0, 1, 1);
    r_phase(1, 1'b1, 1'b0);

    do_write(8, 2, 0, -1, 32'hF0);
    do_write(0, 1, 1, 0, 32'hB0);
    do_read(8, 0, 1, 1'b1);

    do_write(56, 3, 2, -1, 32'hC0);
    do_read(56, 3, 2, 1'b1);
    do_write(4, 2, 2, -1, 32'hD0);

    // Reset in the middle of beat 2 of a 4-beat write.
    ref_mem[8] = 32'h5555_0000;
    exp_w.push_back(32);
    aw_hs(32, 3, 1);
    wvalid = 1; wlast = 0; tb_wdata = 32'h5555_0000;
    @(negedge clk);
    chk("rst_beat1_ready", 32'(axi_wready), 1);
    @(posedge clk); #1 tb_wdata = 32'h5555_0001;
    #2 rst = 1;
    #1 chk("rst_async_outputs", outs(), 0);
    wvalid = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    do_read(32, 3, 1, 1'b0);

    for (int t = 0; t < 60; t++) begin
      a  = $urandom_range(0, 15) * 4;
      bt = $urandom_range(0, 3);
      if (bt == 2 && $urandom_range(0, 1) == 1) ln = wl[$urandom_range(0, 3)];
      else ln = $urandom_range(0, 7);
      bad = ($urandom_range(0, 5) == 0) ? $urandom_range(0, ln) : -1;
      if ($urandom_range(0, 1) == 1) do_write(a, ln, bt, bad, $urandom);
      else do_read(a, ln, bt, 1'($urandom_range(0, 1)));
    end

    repeat (4) @(posedge clk);
    chk("w_queue_empty", 32'(exp_w.size()), 0);
    chk("b_queue_empty", 32'(exp_b.size()), 0);
    chk("r_queue_empty", 32'(exp_r.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
